// File: rtl/bram_poly_reader.sv
// Reads one polynomial (WORDS x 128-bit BRAM words) and streams it as 16-bit coefficients.
// Optional sticky coefficient range check is built when KB_COEF_RANGE_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, first read issued on the accepting edge
// FETCH | issuing BRAM reads while buffer space allows
// DRAIN | all reads issued, serializer emptying the FIFO
// DONE  | one-cycle done pulse, then back to IDLE
module bram_poly_reader #(
   parameter int WORDS   = 32,
   parameter int ADDR_W  = 8,
   parameter int KYBER_Q = 3329
) (
   input  logic              reg_clk,
   input  logic              reg_rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   output logic [15:0]       bram_we,
   input  logic [127:0]      bram_rddata,
   output logic [15:0]       coef_data,
   output logic              coef_valid,
   input  logic              coef_ready,
   output logic              coef_last
`ifdef KB_COEF_RANGE_CHECK_EN
   ,output logic             range_err
`endif
);

   localparam int CNT_W = $clog2(WORDS + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  rd_issued;
   logic [CNT_W-1:0]  words_out;
   logic [127:0]      fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;
   logic              rd_pend;
   logic [2:0]        lane;
   logic              hs;
   logic              pop;
   logic              issue_ok;
   logic              accept;

   assign bram_we    = '0;
   assign accept     = (state == IDLE) && start;
   assign coef_valid = (fifo_cnt != 2'd0);
   assign coef_data  = coef_valid ? fifo_mem[rd_ptr][{lane, 4'd0} +: 16] : 16'd0;
   assign coef_last  = coef_valid && (lane == 3'd7) && (words_out == CNT_W'(WORDS - 1));
   assign hs         = coef_valid && coef_ready;
   assign pop        = hs && (lane == 3'd7);
   // bram_en and rd_pend are the two pipeline stages of a read still on its way to the FIFO
   assign issue_ok   = ({1'b0, fifo_cnt} + {2'b00, bram_en} + {2'b00, rd_pend}) < 3'd2;

   always_ff @(posedge reg_clk or negedge reg_rst_n) begin
      if (!reg_rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         bram_en   <= 1'b0;
         bram_addr <= '0;
         rd_issued <= '0;
      end else begin
         case (state)
            IDLE: begin
               bram_en <= 1'b0;
               done    <= 1'b0;
               if (start) begin
                  bram_en   <= 1'b1;
                  bram_addr <= base_addr;
                  rd_issued <= CNT_W'(1);
                  busy      <= 1'b1;
                  state     <= (WORDS == 1) ? DRAIN : FETCH;
               end
            end
            FETCH: begin
               if (issue_ok) begin
                  bram_en   <= 1'b1;
                  bram_addr <= bram_addr + 1'b1;
                  rd_issued <= rd_issued + 1'b1;
                  if (rd_issued == CNT_W'(WORDS - 1)) state <= DRAIN;
               end else begin
                  bram_en <= 1'b0;
               end
            end
            DRAIN: begin
               bram_en <= 1'b0;
               if (hs && coef_last) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge reg_clk or negedge reg_rst_n) begin
      if (!reg_rst_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
         rd_pend     <= 1'b0;
         lane        <= 3'd0;
         words_out   <= '0;
      end else begin
         rd_pend <= bram_en;
         if (rd_pend) begin
            fifo_mem[wr_ptr] <= bram_rddata;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
         if (accept) begin
            lane      <= 3'd0;
            words_out <= '0;
         end else begin
            if (hs)  lane      <= lane + 3'd1;
            if (pop) words_out <= words_out + 1'b1;
         end
      end
   end

`ifdef KB_COEF_RANGE_CHECK_EN
   localparam logic [15:0] Q16 = 16'(KYBER_Q);

   always_ff @(posedge reg_clk or negedge reg_rst_n) begin
      if (!reg_rst_n)                  range_err <= 1'b0;
      else if (accept)                 range_err <= 1'b0;
      else if (hs && coef_data >= Q16) range_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_bram_poly_reader.sv
// Directed bench for bram_poly_reader: BRAM model, handshake monitor, hand-derived expectations.
module tb_bram_poly_reader;

   logic         reg_clk = 1'b0;
   logic         reg_rst_n;
   logic         start;
   logic [7:0]   base_addr;
   logic         busy, done;
   logic [7:0]   bram_addr;
   logic         bram_en;
   logic [15:0]  bram_we;
   logic [127:0] bram_rddata = '0;
   logic [15:0]  coef_data;
   logic         coef_valid;
   logic         coef_ready = 1'b0;
   logic         coef_last;
`ifdef KB_COEF_RANGE_CHECK_EN
   logic         range_err;
`endif

   bram_poly_reader dut (
      .reg_clk(reg_clk), .reg_rst_n(reg_rst_n), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
      .bram_rddata(bram_rddata), .coef_data(coef_data), .coef_valid(coef_valid),
      .coef_ready(coef_ready), .coef_last(coef_last)
`ifdef KB_COEF_RANGE_CHECK_EN
      , .range_err(range_err)
`endif
   );

   always #5 reg_clk = ~reg_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // stimulus/monitor state
   int         cyc = 0;
   int         ready_pct = 100;
   logic [7:0] cur_base = 8'h00;
   bit         ov_en = 1'b0;
   int         ov_idx = 0;
   logic [15:0] ov_val = 16'd0;
   bit         mon_en = 1'b0;
   logic [7:0] reads[$];
   int n_hs, n_done, n_last, last_idx, last_cyc, done_cyc, start_cyc, first_valid;
   int data_err, stab_err, last_err, max_outst, outst;
   bit stall_prev;
   logic [15:0] stall_data;
   logic re_at_hs;

   always @(posedge reg_clk) cyc <= cyc + 1;

   always @(posedge reg_clk) begin
      #1;
      coef_ready = ($urandom_range(0, 99) < ready_pct);
   end

   function automatic logic [15:0] exp_coef(input int i);
      if (ov_en && i == ov_idx) return ov_val;
      return 16'(i);
   endfunction

   // BRAM: word n at cur_base+n holds coefficients 8n..8n+7, lane 0 lowest
   always @(posedge reg_clk) begin
      if (bram_en) begin
         logic [7:0] n;
         n = bram_addr - cur_base;
         for (int k = 0; k < 8; k++) bram_rddata[16*k +: 16] <= exp_coef(8 * int'(n) + k);
      end
   end

   always @(negedge reg_clk) begin
      if (mon_en) begin
         if (bram_en) reads.push_back(bram_addr);
         outst = reads.size() - n_hs / 8;
         if (outst > max_outst) max_outst = outst;
         if (coef_valid && first_valid < 0) first_valid = cyc;
         if (stall_prev && (!coef_valid || coef_data !== stall_data)) stab_err++;
         stall_prev = coef_valid && !coef_ready;
         stall_data = coef_data;
         if (coef_last && !coef_valid) last_err++;
         if (coef_valid && coef_ready) begin
            if (coef_data !== exp_coef(n_hs)) data_err++;
            if (coef_last) begin
               n_last++;
               last_idx = n_hs;
               last_cyc = cyc;
            end
`ifdef KB_COEF_RANGE_CHECK_EN
            if (ov_en && n_hs == ov_idx) re_at_hs = range_err;
`endif
            n_hs++;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clear_mon(input logic [7:0] base);
      reads.delete();
      n_hs = 0; n_done = 0; n_last = 0; last_idx = -1; last_cyc = -1; done_cyc = -1;
      start_cyc = -1; first_valid = -1; data_err = 0; stab_err = 0; last_err = 0;
      max_outst = 0; stall_prev = 1'b0; re_at_hs = 1'b0;
      cur_base = base;
      mon_en = 1'b1;
   endtask

   task automatic start_poly(input logic [7:0] base);
      @(posedge reg_clk); #1;
      start = 1'b1;
      base_addr = base;
      start_cyc = cyc;
      @(posedge reg_clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 6000 && n_done == 0; i++) @(posedge reg_clk);
      chk({tag, "_done_seen"}, 32'(n_done > 0), 1);
      repeat (6) @(posedge reg_clk);
      mon_en = 1'b0;
   endtask

   task automatic check_run(input string tag, input bit chk_latency);
      int addr_err = 0;
      foreach (reads[i]) if (reads[i] !== 8'(int'(cur_base) + i)) addr_err++;
      chk({tag, "_n_coef"}, 32'(n_hs), 256);
      chk({tag, "_data"}, 32'(data_err), 0);
      chk({tag, "_n_last"}, 32'(n_last), 1);
      chk({tag, "_last_idx"}, 32'(last_idx), 255);
      chk({tag, "_last_stray"}, 32'(last_err), 0);
      chk({tag, "_n_reads"}, 32'(reads.size()), 32);
      chk({tag, "_addr"}, 32'(addr_err), 0);
      chk({tag, "_n_done"}, 32'(n_done), 1);
      chk({tag, "_done_lat"}, 32'(done_cyc - last_cyc), 1);
      chk({tag, "_stable"}, 32'(stab_err), 0);
      chk({tag, "_outstanding_le2"}, 32'(max_outst <= 2), 1);
      if (chk_latency) chk({tag, "_first_valid_lat"}, 32'(first_valid - start_cyc), 3);
   endtask

   task automatic run_poly(input string tag, input logic [7:0] base, input bit chk_latency);
      clear_mon(base);
      start_poly(base);
      wait_done(tag);
      check_run(tag, chk_latency);
   endtask

   initial begin
      reg_rst_n = 1'b0;
      start     = 1'b0;
      base_addr = 8'h00;
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_bram_en", 32'(bram_en), 0);
      chk("rst_bram_addr", 32'(bram_addr), 0);
      chk("rst_coef_valid", 32'(coef_valid), 0);
      chk("rst_coef_data", 32'(coef_data), 0);
      chk("rst_coef_last", 32'(coef_last), 0);
      chk("bram_we_zero", 32'(bram_we), 0);
      repeat (3) @(posedge reg_clk);
      #1 reg_rst_n = 1'b1;

      ready_pct = 100;
      run_poly("base10", 8'h10, 1'b1);
      chk("base10_busy_after", 32'(busy), 0);

      run_poly("wrapF0", 8'hF0, 1'b1);

      ready_pct = 30;
      run_poly("rdy30", 8'h40, 1'b0);
      ready_pct = 100;

      // second start while busy must be ignored
      clear_mon(8'h20);
      start_poly(8'h20);
      repeat (20) @(posedge reg_clk);
      #1 start = 1'b1; base_addr = 8'h80;
      @(posedge reg_clk); #1 start = 1'b0;
      wait_done("restart");
      check_run("restart", 1'b1);

      // reset in the middle of a transfer
      clear_mon(8'h00);
      start_poly(8'h00);
      for (int i = 0; i < 2000 && n_hs < 101; i++) @(posedge reg_clk);
      chk("midrst_reached_101", 32'(n_hs >= 101), 1);
      #1 reg_rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_bram_en", 32'(bram_en), 0);
      chk("midrst_bram_addr", 32'(bram_addr), 0);
      chk("midrst_coef_valid", 32'(coef_valid), 0);
      chk("midrst_coef_data", 32'(coef_data), 0);
      chk("midrst_coef_last", 32'(coef_last), 0);
      chk("midrst_done", 32'(done), 0);
      repeat (2) @(posedge reg_clk);
      #1 reg_rst_n = 1'b1;
      repeat (10) @(posedge reg_clk);
      chk("midrst_no_done", 32'(n_done), 0);
      chk("midrst_idle_busy", 32'(busy), 0);
      mon_en = 1'b0;
      run_poly("after_rst", 8'h00, 1'b1);

`ifdef KB_COEF_RANGE_CHECK_EN
      chk("rc_initial", 32'(range_err), 0);
      ov_en = 1'b1; ov_idx = 26; ov_val = 16'd3329;
      run_poly("rc3329", 8'h00, 1'b0);
      chk("rc3329_before", 32'(re_at_hs), 0);
      chk("rc3329_sticky", 32'(range_err), 1);
      ov_val = 16'd3328;
      run_poly("rc3328", 8'h00, 1'b0);
      chk("rc3328_clear", 32'(range_err), 0);
      ov_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
